// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture state encoding and default widths.
// Used by the PWM generator and by the capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    CAP_ACQUIRE = 2'd0,
    CAP_HIGH    = 2'd1,
    CAP_LOW     = 2'd2,
    CAP_STUCK   = 2'd3
  } cap_state_e;

  localparam int unsigned PWM_CNT_WIDTH   = 16;
  localparam int unsigned PWM_SYNC_STAGES = 2;
  localparam int unsigned PWM_TIMEOUT     = 1024;

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchroniser: a chain of STAGES flops, all cleared by reset.
// STAGES must be at least 2.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles,
// with a strobe per complete period and a stuck-input detector.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = PWM_CNT_WIDTH,
  parameter int unsigned SYNC_STAGES = PWM_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = PWM_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] high_cnt,
  output logic [CNT_WIDTH-1:0] period_cnt,
  output logic                 meas_valid,
  output logic                 stuck,
  output logic                 stuck_level
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

  logic                 sync;
  logic                 sync_prev_q;
  logic                 rise;
  logic                 fall;
  cap_state_e           state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] hold_high_q;
  logic [CNT_WIDTH-1:0] high_cnt_q;
  logic [CNT_WIDTH-1:0] period_cnt_q;
  logic                 meas_valid_q;
  logic                 stuck_q;
  logic                 stuck_level_q;
  logic                 timeout;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(pwm_in),
    .q_o(sync)
  );

  assign rise  = sync & ~sync_prev_q;
  assign fall  = ~sync & sync_prev_q;
  assign cnt_d = cnt_q + CNT_ONE;

  // A rise landing on the limit cycle is a real edge and beats the timeout.
  assign timeout = ((state_q == CAP_HIGH) || (state_q == CAP_LOW)) &&
                   (cnt_q == CNT_LIMIT) && !rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_prev_q   <= 1'b0;
      state_q       <= CAP_ACQUIRE;
      cnt_q         <= '0;
      hold_high_q   <= '0;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      sync_prev_q  <= sync;
      meas_valid_q <= 1'b0;
      if (timeout) begin
        state_q       <= CAP_STUCK;
        stuck_q       <= 1'b1;
        stuck_level_q <= sync;
        high_cnt_q    <= '0;
        period_cnt_q  <= '0;
        meas_valid_q  <= 1'b1;
      end else begin
        case (state_q)
          CAP_ACQUIRE: begin
            if (rise) begin
              cnt_q   <= CNT_ONE;
              state_q <= CAP_HIGH;
            end
          end
          CAP_HIGH: begin
            cnt_q <= cnt_d;
            if (fall) begin
              hold_high_q <= cnt_q;
              state_q     <= CAP_LOW;
            end
          end
          CAP_LOW: begin
            if (rise) begin
              high_cnt_q   <= hold_high_q;
              period_cnt_q <= cnt_q;
              meas_valid_q <= 1'b1;
              cnt_q        <= CNT_ONE;
              state_q      <= CAP_HIGH;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          CAP_STUCK: begin
            if (rise) begin
              stuck_q <= 1'b0;
              cnt_q   <= CNT_ONE;
              state_q <= CAP_HIGH;
            end else if (fall) begin
              stuck_q <= 1'b0;
              cnt_q   <= '0;
              state_q <= CAP_ACQUIRE;
            end
          end
          default: state_q <= CAP_ACQUIRE;
        endcase
      end
    end
  end

  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign meas_valid  = meas_valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform, such as the output of the team's edge PWM generator or an external PWM source, and reports its high time and period in clock cycles. It synchronises the asynchronous input, detects edges and counts cycles. At the end of each complete period it emits a single-cycle measurement strobe. The block is the receive-side counterpart of the PWM generator and is used for loopback self-test and for reading externally generated PWM signals.

## Interface
- CNT_WIDTH, 16: width of the cycle counters and of both result outputs.
- SYNC_STAGES, 2: depth of the input synchroniser. Must be at least 2.
- TIMEOUT, 1024: number of cycles without an edge before the input is declared stuck. Must satisfy 2 ≤ TIMEOUT < 2^CNT_WIDTH.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  1  PWM input. It is asynchronous to clk.
- high_cnt  out  CNT_WIDTH  last measured high time, in cycles.
- period_cnt  out  CNT_WIDTH  last measured period, in cycles (rising edge to rising edge).
- meas_valid  out  1  one-cycle strobe indicating that high_cnt and period_cnt have just been updated.
- stuck  out  1  level signal, high while no edge has been seen for TIMEOUT cycles.
- stuck_level  out  1  synchronised pwm_in level, captured when stuck was asserted.

## Operation
- **Synchroniser.** pwm_in passes through SYNC_STAGES flops, all reset to 0. One further flop holds the previous synchronised value (sync_d).
  - rise = sync & ~sync_d
  - fall = ~sync & sync_d
- **States.** ACQUIRE (the reset state), HIGH, LOW, STUCK.
- **ACQUIRE**
  - rise: cnt ← 1, go to HIGH.
  - No measurement is emitted from this state.
  - cnt does not run in ACQUIRE, so a constant input after reset is never flagged as stuck.
- **HIGH**
  - fall: hold_high ← cnt, cnt ← cnt+1, go to LOW.
  - Otherwise cnt ← cnt+1.
- **LOW**
  - rise: high_cnt ← hold_high, period_cnt ← cnt, meas_valid ← 1, cnt ← 1, go to HIGH.
  - Otherwise cnt ← cnt+1.
- **Timeout.** In HIGH or LOW, if cnt reaches TIMEOUT with no edge:
  - go to STUCK;
  - stuck ← 1, stuck_level ← sync;
  - high_cnt ← 0, period_cnt ← 0, meas_valid ← 1 for one cycle.
- **STUCK**
  - rise: stuck ← 0, cnt ← 1, go to HIGH. No measurement is emitted for this transition.
  - fall (a stuck-high input going low): stuck ← 0, go to ACQUIRE.
- **Counter width.** cnt is CNT_WIDTH bits and never exceeds TIMEOUT, so it cannot wrap.
- **Simultaneous events.** A rise detected on the same cycle that cnt reaches TIMEOUT counts as an edge. The edge wins and the timeout is not taken.
- **Reset mid-operation.** All state is cleared immediately and any partially counted period is discarded. The first valid measurement after reset needs two rising edges.
- **Degenerate input.** A one-cycle-high input is a valid measurement (high_cnt = 1). Pulses shorter than one clock may be missed; this is accepted.

## Timing
- **Reset values.** high_cnt = 0, period_cnt = 0, meas_valid = 0, stuck = 0, stuck_level = 0, state = ACQUIRE, cnt = 0.
- **Latency.** All outputs are registered. A pwm_in level first sampled at clock edge k produces its edge detection during the cycle after edge k+SYNC_STAGES−1. The corresponding outputs update at edge k+SYNC_STAGES.
- **Result stability.** high_cnt and period_cnt change only on cycles where meas_valid is high, and hold their values between strobes.
- **Strobe width and rate.** meas_valid is exactly one cycle wide, with at most one strobe per period.
- **Minimum measurable period.** 2 cycles.

## Structure
- **Shared package pwm_pkg.** Contains the capture state enum (ACQUIRE, HIGH, LOW, STUCK) and the default width constants. This package is shared with the PWM generator.
- **Sub-module bit_sync.** Parameterised by SYNC_STAGES. It is a flop chain with asynchronous reset to 0 and is reusable elsewhere.
- **Top level.** Contains the edge detector, the state machine, cnt, the hold_high register and the output registers.

## Test plan
- **Reset.** Hold rst with pwm_in toggling → all outputs 0 and no meas_valid. Release mid-period → no strobe until after the second rising edge.
- **Steady waveform.** Drive 64 cycles high and 192 cycles low, repeating → every strobe reports high_cnt = 64, period_cnt = 256, exactly one strobe per period, and the first strobe at the second rising edge plus sync latency.
- **Duty change.** Switch from 64/256 to 128/256 at a period boundary → next strobe reports 128/256 with no mixed values. Also run the bench's own edge PWM generator in loopback at duty 0, 8, 128 and 255 and check against its programmed period.
- **Stuck low.** Hold pwm_in at 0 for 2000 cycles with TIMEOUT = 1024 → stuck = 1, stuck_level = 0, one zero-valued strobe 1024 cycles after the last rise. Restart the waveform → stuck clears at the rise and the next strobe comes after a full period.
- **Stuck high.** Hold pwm_in at 1 → stuck = 1, stuck_level = 1. On the falling edge stuck clears and the state returns to ACQUIRE.
- **Edges.** 1 cycle high, 9 cycles low → high_cnt = 1, period_cnt = 10. Place a rise on the exact TIMEOUT cycle → no stuck assertion.
